// File: rtl/axis_trigger_window_pkg.sv
// Shared types and widths for the trigger-gated AXI4-Stream capture stage.
package axis_trigger_window_pkg;

  localparam int TW_CNTR_WIDTH = 32;
  // Window counter carries one extra bit so P+Q never wraps.
  localparam int TW_CNT_W = TW_CNTR_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_WAIT = 3'd2,
    ST_CAPT = 3'd3,
    ST_DONE = 3'd4
  } tw_state_e;

endpackage

// File: rtl/axis_delay_ram.sv
// Simple dual-port delay memory: one write port, one registered read port.
module axis_delay_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              aclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge aclk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Unreset read register keeps this mappable onto a block RAM output latch.
  always_ff @(posedge aclk) begin
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_trigger_window.sv
// Delays the ADC stream through a circular buffer and, once armed and triggered,
// emits one window of pre_samples + post_samples beats ending with tlast.
module axis_trigger_window
  import axis_trigger_window_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = TW_CNT_W - 1,
  parameter int PRE_ADDR_WIDTH   = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        arm,
  input  logic                        trigger,
  input  logic [PRE_ADDR_WIDTH-1:0]   pre_samples,
  input  logic [CNTR_WIDTH-1:0]       post_samples,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [2:0]                  dbg_state
);

  localparam int CNT_W = CNTR_WIDTH + 1;

  // Handshake: the source is never stalled (tready tied high); a beat moves on
  // every cycle with s_axis_tvalid. Output beats are one-cycle tvalid pulses and
  // m_axis_tready is only observed to flag overflow, never to hold data.

  tw_state_e                   state_q, state_d;
  logic                        arm_q, arm_q2, arm_edge;
  logic [PRE_ADDR_WIDTH-1:0]   wr_ptr, rd_addr, p_lat, fill_cnt;
  logic [PRE_ADDR_WIDTH:0]     fill_nxt;
  logic [CNTR_WIDTH-1:0]       q_lat;
  logic [CNT_W-1:0]            win_cnt, win_len, win_dec;
  logic                        start, fill_inc, load_win, dec_win, emit, last;
  logic                        sel_byp;
  logic [AXIS_TDATA_WIDTH-1:0] byp_q, ram_rd;

  assign s_axis_tready = 1'b1;
  assign arm_edge      = arm_q & ~arm_q2;
  assign fill_nxt      = {1'b0, fill_cnt} + {{PRE_ADDR_WIDTH{1'b0}}, 1'b1};
  assign win_len       = CNT_W'(p_lat) + CNT_W'(q_lat);
  assign win_dec       = win_cnt - CNT_W'(1);
  assign rd_addr       = wr_ptr - p_lat;

  axis_delay_ram #(
    .DATA_W (AXIS_TDATA_WIDTH),
    .ADDR_W (PRE_ADDR_WIDTH)
  ) u_ram (
    .aclk    (aclk),
    .we      (s_axis_tvalid),
    .wr_addr (wr_ptr),
    .wr_data (s_axis_tdata),
    .re      (s_axis_tvalid),
    .rd_addr (rd_addr),
    .rd_data (ram_rd)
  );

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    fill_inc = 1'b0;
    load_win = 1'b0;
    dec_win  = 1'b0;
    emit     = 1'b0;
    last     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_edge) begin
          start   = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (p_lat == '0) begin
          state_d = ST_WAIT;
        end else if (s_axis_tvalid) begin
          fill_inc = 1'b1;
          if (fill_nxt == {1'b0, p_lat}) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s_axis_tvalid && trigger) begin
          if (win_len == '0) begin
            state_d = ST_DONE;
          end else begin
            emit     = 1'b1;
            load_win = 1'b1;
            last     = (win_len == CNT_W'(1));
            state_d  = last ? ST_DONE : ST_CAPT;
          end
        end
      end
      ST_CAPT: begin
        if (s_axis_tvalid) begin
          emit    = 1'b1;
          dec_win = 1'b1;
          last    = (win_dec == '0);
          if (last) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      arm_q         <= 1'b0;
      arm_q2        <= 1'b0;
      p_lat         <= '0;
      q_lat         <= '0;
      fill_cnt      <= '0;
      win_cnt       <= '0;
      wr_ptr        <= '0;
      sel_byp       <= 1'b1;
      byp_q         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm;
      arm_q2  <= arm_q;
      if (start) begin
        p_lat    <= pre_samples;
        q_lat    <= post_samples;
        fill_cnt <= '0;
      end else if (fill_inc) begin
        fill_cnt <= fill_nxt[PRE_ADDR_WIDTH-1:0];
      end
      if (load_win)     win_cnt <= win_len - CNT_W'(1);
      else if (dec_win) win_cnt <= win_dec;
      // Bypass path lines up with the RAM read register so either source has 1-cycle latency.
      if (s_axis_tvalid) begin
        wr_ptr  <= wr_ptr + PRE_ADDR_WIDTH'(1);
        sel_byp <= (p_lat == '0);
        byp_q   <= s_axis_tdata;
      end
      m_axis_tvalid <= emit;
      m_axis_tlast  <= last;
      if (start)                               overflow <= 1'b0;
      else if (m_axis_tvalid && !m_axis_tready) overflow <= 1'b1;
    end
  end

  assign m_axis_tdata = sel_byp ? byp_q : ram_rd;
  assign busy         = (state_q == ST_FILL) || (state_q == ST_WAIT) || (state_q == ST_CAPT);
  assign done         = (state_q == ST_DONE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_axis_trigger_window.sv
// Randomized bench for axis_trigger_window with a beat-index reference model and scoreboard.
module tb_axis_trigger_window;
  import axis_trigger_window_pkg::*;

  localparam int W    = 32;
  localparam int CW   = 32;
  localparam int A    = 5;
  localparam int NMEM = 16384;

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_WAIT = 2;
  localparam int M_CAPT = 3;
  localparam int M_DONE = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          arm = 1'b0;
  logic          trigger = 1'b0;
  logic [A-1:0]  pre_samples = '0;
  logic [CW-1:0] post_samples = '0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [2:0]    dbg_state;

  axis_trigger_window #(
    .AXIS_TDATA_WIDTH (W),
    .CNTR_WIDTH       (CW),
    .PRE_ADDR_WIDTH   (A)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .arm           (arm),
    .trigger       (trigger),
    .pre_samples   (pre_samples),
    .post_samples  (post_samples),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  logic [W-1:0] x_mem [NMEM];

  // reference model: beat indices and the window rules, not the RTL's registers
  int beat_idx = 0;
  int cyc = 0;
  int m_phase = M_IDLE;
  int m_p = 0, m_q = 0, fill_seen = 0, fill_from = 0, wait_from = 0, left = 0;
  bit arm_prev = 1'b0;
  bit tog = 1'b0;
  bit bp_low = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge aclk) begin
    if (m_axis_tvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got tlast=%0b data=%0h, expected no beat",
                 m_axis_tlast, m_axis_tdata);
      end else begin
        check("beat", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver ----------------
  function automatic bit next_valid(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) begin
      tog = ~tog;
      return tog;
    end
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic drive(input bit v, input bit trg, input bit a);
    @(negedge aclk);
    aresetn       = 1'b1;
    s_axis_tvalid = v;
    trigger       = trg;
    arm           = a;
    m_axis_tready = !bp_low;
    s_axis_tdata  = v ? x_mem[beat_idx] : $urandom;
    if (a && !arm_prev && (m_phase == M_IDLE || m_phase == M_DONE)) begin
      m_p = int'(pre_samples);
      m_q = int'(post_samples);
      fill_seen = 0;
      if (m_p == 0) begin
        m_phase   = M_WAIT;
        wait_from = cyc + 3;
      end else begin
        m_phase   = M_FILL;
        fill_from = cyc + 2;
      end
    end else if (m_phase == M_FILL) begin
      if (v && cyc >= fill_from) begin
        fill_seen++;
        if (fill_seen == m_p) begin
          m_phase   = M_WAIT;
          wait_from = cyc + 1;
        end
      end
    end else if (m_phase == M_WAIT) begin
      if (v && trg && cyc >= wait_from) begin
        for (int i = 0; i < m_p + m_q; i++)
          exp_q.push_back({(i == m_p + m_q - 1), x_mem[beat_idx - m_p + i]});
        left    = m_p + m_q - 1;
        m_phase = (left <= 0) ? M_DONE : M_CAPT;
      end
    end else if (m_phase == M_CAPT) begin
      if (v) begin
        left--;
        if (left == 0) m_phase = M_DONE;
      end
    end
    if (v) beat_idx++;
    arm_prev = a;
    cyc++;
  endtask

  task automatic reset_dut();
    @(negedge aclk);
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    arm           = 1'b0;
    trigger       = 1'b0;
    bp_low        = 1'b0;
    m_axis_tready = 1'b1;
    arm_prev      = 1'b0;
    m_phase       = M_IDLE;
    cyc++;
    @(posedge aclk);
    #1;
    exp_q.delete();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tready", s_axis_tready, 1);
    check("rst_state", dbg_state, ST_IDLE);
  endtask

  task automatic capture(input int p, input int q, input int vmode, input bit trig_early,
                         input bit bp, input int pre_cycles);
    int n;
    pre_samples  = A'(p);
    post_samples = CW'(q);
    drive(next_valid(vmode), trig_early, 1'b1);
    drive(next_valid(vmode), trig_early, 1'b0);
    repeat (pre_cycles) drive(next_valid(vmode), trig_early, 1'b0);
    n = 0;
    while (!(m_phase == M_CAPT || m_phase == M_DONE) && n < 500) begin
      drive(next_valid(vmode), 1'b1, 1'b0);
      n++;
    end
    check("trigger_timeout", n < 500, 1);
    n = 0;
    while ((m_phase != M_DONE || exp_q.size() != 0) && n < 500) begin
      bp_low = bp && (n == 3 || n == 4);
      drive(next_valid(vmode), 1'b0, 1'b0);
      n++;
    end
    bp_low = 1'b0;
    check("window_timeout", n < 500, 1);
    repeat (3) drive(next_valid(vmode), 1'b0, 1'b0);
    check("done_after", done, 1);
    check("busy_after", busy, 0);
    check("overflow_after", overflow, bp);
    check("state_after", dbg_state, ST_DONE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NMEM; i++) x_mem[i] = $urandom;
    reset_dut();
    repeat (20) drive(1'b1, 1'b0, 1'b0);

    capture(4, 8, 0, 1'b0, 1'b0, 80);
    capture(0, 3, 0, 1'b0, 1'b0, 10);
    capture(5, 0, 0, 1'b0, 1'b0, 10);
    capture(0, 0, 0, 1'b0, 1'b0, 5);
    capture(1, 0, 0, 1'b0, 1'b0, 3);
    capture(0, 1, 1, 1'b0, 1'b0, 3);
    capture(16, 6, 0, 1'b1, 1'b0, 0);
    capture(15, 20, 1, 1'b0, 1'b0, 4);
    capture(31, 20, 1, 1'b0, 1'b0, 4);
    capture(6, 10, 0, 1'b0, 1'b1, 5);
    capture(3, 4, 0, 1'b0, 1'b0, 2);
    for (int k = 0; k < 6; k++)
      capture($urandom_range(0, 31), $urandom_range(0, 40), 2, 1'($urandom_range(0, 1)),
              1'b0, $urandom_range(0, 10));

    // arm during an active window is ignored; reset mid-window aborts it
    pre_samples  = A'(8);
    post_samples = CW'(30);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 200 && m_phase != M_CAPT; n++) drive(1'b1, 1'b1, 1'b0);
    repeat (5) drive(1'b1, 1'b0, 1'b0);
    pre_samples  = A'(3);
    post_samples = CW'(2);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check("arm_in_capt_state", dbg_state, ST_CAPT);
    check("arm_in_capt_busy", busy, 1);
    reset_dut();
    capture(3, 2, 0, 1'b0, 1'b0, 3);
    capture(7, 5, 2, 1'b0, 1'b0, 6);

    repeat (5) drive(1'b1, 1'b0, 1'b0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_trigger_window.md
# axis_trigger_window

Trigger-gated capture stage placed directly downstream of the level-crossing detector. It delays the free-running ADC AXI4-Stream through a circular buffer so that pre-trigger history is available. When armed and the detector's `state_out` asserts, it emits one contiguous window of `pre_samples` + `post_samples` beats, with `tlast` on the final beat, toward the DMA/FIFO writer.

## Interface
- `AXIS_TDATA_WIDTH`, 32, sample width.
- `CNTR_WIDTH`, 32, width of `post_samples` and the window counter.
- `PRE_ADDR_WIDTH`, 10, delay buffer depth is 2^`PRE_ADDR_WIDTH`.

- `aclk` in 1: clock.
- `aresetn` in 1: reset, synchronous, active-low; clock `aclk`.
- `arm` in 1: a rising edge starts a capture.
- `trigger` in 1: level trigger, normally the level-crossing `state_out`.
- `pre_samples` in `PRE_ADDR_WIDTH`: pre-trigger length P, 0..2^A−1; latched on arm.
- `post_samples` in `CNTR_WIDTH`: post-trigger length Q; latched on arm.
- `s_axis_tdata` in `AXIS_TDATA_WIDTH`: input samples.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tready` out 1: constant 1.
- `m_axis_tdata` out `AXIS_TDATA_WIDTH`: windowed samples.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tlast` out 1: last beat of the window.
- `m_axis_tready` in 1: downstream ready.
- `busy` out 1: high in FILL, WAIT or CAPT.
- `done` out 1: sticky; high in DONE.
- `overflow` out 1: sticky; a beat was emitted while `m_axis_tready` was low.

## Operation
- **Delay line.** Every input beat n writes x[n] at `wr_ptr`, and `wr_ptr` increments modulo 2^A. The read address is `wr_ptr` − P in the same cycle, so the delayed sample is x[n−P]. When P = 0, bypass the RAM and use x[n] directly. The delay line runs in every state, including IDLE.
- **Arm.** `arm` is registered for edge detection. A rising edge in IDLE or DONE does the following:
  - latches P and Q;
  - clears `done` and `overflow`;
  - zeroes the fill counter;
  - enters FILL.
- Arm edges in FILL, WAIT or CAPT are ignored.
- **States:**
  - IDLE: wait for arm.
  - FILL: count input beats. After P beats, enter WAIT. P = 0 goes to WAIT on the next cycle. The trigger is ignored in FILL, including on the beat that completes the fill.
  - WAIT: the first input beat n with `trigger` = 1 in that cycle starts the window. The trigger is level-sensitive, so upstream must be cleared before arming.
  - CAPT: emit the delayed sample of each input beat, starting with beat n (data x[n−P]), for P+Q beats total.
  - DONE: set `done`; emit nothing further.
- **Window counter.** Width is `CNTR_WIDTH`+1. It loads P+Q−1 on the trigger beat and decrements on each emitted beat. `tlast` is asserted on the beat where the counter equals 0, and the state then goes to DONE.
- **Empty window.** If P+Q = 0, the trigger beat goes straight to DONE, with no beats and no `tlast`.
- **Backpressure.** The source cannot stall. A beat emitted while `m_axis_tready` = 0 is still counted and is overwritten on the next beat. `overflow` sets in that cycle.
- **Gaps.** `s_axis_tvalid` gaps pause all counting and emission and do not corrupt alignment.
- **Reset.** Asserting `aresetn` mid-operation returns to IDLE and clears `wr_ptr` and all counters. RAM contents are don't-care.

## Timing
- Output latency is 1 cycle: the beat accepted at cycle k appears on m_axis at cycle k+1.
- `m_axis_tvalid` is high for exactly one cycle per emitted beat; `tdata` is registered.
- `arm` rising at cycle c is registered at c+1, and the state is FILL from c+2.
- `done` is high from the cycle after the `tlast` beat.
- `busy` and `done` are never high together.
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `busy`, `done`, `overflow` = 0;
  - `m_axis_tdata` = 0;
  - `s_axis_tready` = 1 always.

## Structure
- Shared package `axis_trigger_window_pkg` holds:
  - state encoding constants `ST_IDLE`, `ST_FILL`, `ST_WAIT`, `ST_CAPT`, `ST_DONE` (3 bits);
  - `TW_CNT_W` = `CNTR_WIDTH`+1.
- Sub-module `axis_delay_ram`: simple dual-port RAM, 2^A × `AXIS_TDATA_WIDTH`, one write port and one registered read port. It must infer block RAM.
- The top level contains the FSM, counters, P=0 bypass mux and output register.

## Test plan
- **Basic window.** Ramp input x[n] = n, continuous valid. P=4, Q=8, arm, then `trigger` high at input beat 100 → 12 beats with data 96..107, `tlast` on 107, `done` = 1 afterward, `overflow` = 0.
- **P=0 / Q=0 corners.** P=0, Q=3, trigger at beat 50 → data 50,51,52. P=5, Q=0 → data 45..49. P=0, Q=0 → no beats and `done` = 1.
- **Trigger during FILL ignored.** P=16, trigger held high from arm → the window starts at the first beat after the 16th fill beat. The first emitted datum equals that beat index − 16.
- **Gaps and wrap.** A=4 (depth 16), P=15, Q=20, valid toggling 1-0-1-0 across a `wr_ptr` wrap → 35 contiguous ramp values, no duplicates or skips.
- **Backpressure.** Hold `m_axis_tready` low for 2 cycles mid-window → still exactly P+Q valid beats and `overflow` = 1. Re-arming clears `overflow`.
- **Reset and re-arm.** Assert `aresetn` low during CAPT → next cycle all outputs are at reset values and state is IDLE. Arm in CAPT is ignored. Arm from DONE starts a new capture with newly latched P and Q.
